// File: rtl/display_arbiter.sv
// Two-requester arbiter for the four-digit 7-segment display: minimum hold time, round-robin
// ties and a one-cycle blanked gap on handover. Optional preemption: DISPLAY_ARBITER_PREEMPT_EN.
module display_arbiter #(
    parameter int unsigned TICK_DIV   = 12_500_000,
    parameter int unsigned HOLD_TICKS = 4,
    parameter int unsigned MAX_HOLD   = 16
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Req0,
    input  logic [15:0] i_Datos0,
    input  logic        i_Req1,
    input  logic [15:0] i_Datos1,
    output logic        o_Gnt0,
    output logic        o_Gnt1,
    output logic [3:0]  o_Datos1,
    output logic [3:0]  o_Datos2,
    output logic [3:0]  o_Datos3,
    output logic [3:0]  o_Datos4,
    output logic        o_Blank
);

    localparam int unsigned PrescW = $clog2(TICK_DIV);
`ifdef DISPLAY_ARBITER_PREEMPT_EN
    localparam bit PreemptEn = 1'b1;
`else
    localparam bit PreemptEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1, StSwitch} state_e;

    state_e              r_state;
    logic                r_last;
    logic                r_target;
    logic                r_gnt0;
    logic                r_gnt1;
    logic                r_blank;
    logic [15:0]         r_dat;
    logic [PrescW-1:0]   r_presc;
    logic [7:0]          r_hold;

    logic                w_tick;
    logic [7:0]          w_hold_nxt;
    logic                w_hold_done;
    logic                w_own_id;
    logic                w_own_req;
    logic                w_oth_req;
    logic [15:0]         w_own_dat;
    logic                w_preempt;
    logic                w_enter;
    logic                w_enter_id;
    logic [15:0]         w_enter_dat;

    // Hold decisions use the count as it will be after this edge, so ownership ends
    // exactly HOLD_TICKS*TICK_DIV cycles after the grant edge.
    always_comb begin
        w_tick     = (r_presc == PrescW'(TICK_DIV - 1));
        w_hold_nxt = r_hold;
        if (w_tick && (r_hold != 8'hFF)) begin
            w_hold_nxt = r_hold + 8'd1;
        end
        w_hold_done = (w_hold_nxt >= 8'(HOLD_TICKS));
        w_own_id    = (r_state == StOwn1);
        w_own_req   = w_own_id ? i_Req1 : i_Req0;
        w_oth_req   = w_own_id ? i_Req0 : i_Req1;
        w_own_dat   = w_own_id ? i_Datos1 : i_Datos0;
        w_preempt   = PreemptEn && w_own_req && w_oth_req && (w_hold_nxt >= 8'(MAX_HOLD));

        w_enter    = 1'b0;
        w_enter_id = 1'b0;
        if (r_state == StIdle) begin
            w_enter    = i_Req0 || i_Req1;
            w_enter_id = (i_Req0 && i_Req1) ? ~r_last : i_Req1;
        end else if (r_state == StSwitch) begin
            w_enter    = r_target ? i_Req1 : i_Req0;
            w_enter_id = r_target;
        end
        w_enter_dat = w_enter_id ? i_Datos1 : i_Datos0;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state  <= StIdle;
            r_last   <= 1'b1;
            r_target <= 1'b0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_blank  <= 1'b1;
            r_dat    <= '0;
            r_presc  <= '0;
            r_hold   <= '0;
        end else if (w_enter) begin
            r_state <= w_enter_id ? StOwn1 : StOwn0;
            r_gnt0  <= ~w_enter_id;
            r_gnt1  <= w_enter_id;
            r_dat   <= w_enter_dat;
            r_last  <= w_enter_id;
            r_presc <= '0;
            r_hold  <= '0;
            r_blank <= 1'b0;
        end else begin
            unique case (r_state)
                StOwn0, StOwn1: begin
                    r_presc <= w_tick ? '0 : r_presc + PrescW'(1);
                    r_hold  <= w_hold_nxt;
                    if ((!w_own_req && w_hold_done) || w_preempt) begin
                        r_gnt0   <= 1'b0;
                        r_gnt1   <= 1'b0;
                        r_blank  <= 1'b1;
                        r_target <= ~w_own_id;
                        r_state  <= w_oth_req ? StSwitch : StIdle;
                    end else begin
                        // Dropped request freezes the digits but keeps ownership.
                        r_gnt0 <= w_own_req && !w_own_id;
                        r_gnt1 <= w_own_req && w_own_id;
                        if (w_own_req) begin
                            r_dat <= w_own_dat;
                        end
                    end
                end
                StSwitch: r_state <= StIdle;
                default: ;
            endcase
        end
    end

    assign o_Gnt0   = r_gnt0;
    assign o_Gnt1   = r_gnt1;
    assign o_Blank  = r_blank;
    assign o_Datos1 = r_dat[15:12];
    assign o_Datos2 = r_dat[11:8];
    assign o_Datos3 = r_dat[7:4];
    assign o_Datos4 = r_dat[3:0];

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter: table-driven vectors feeding a scoreboard queue,
// plus hand-built idle and continuous-contention sequences.
module tb_display_arbiter;

    localparam int unsigned TickDiv   = 4;
    localparam int unsigned HoldTicks = 2;
    localparam int unsigned MaxHold   = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [15:0] d0 = '0;
    logic [15:0] d1 = '0;
    logic        gnt0;
    logic        gnt1;
    logic        blank;
    logic [3:0]  q1;
    logic [3:0]  q2;
    logic [3:0]  q3;
    logic [3:0]  q4;
    logic [15:0] dat;

    assign dat = {q1, q2, q3, q4};

    always #5 clk = ~clk;

    display_arbiter #(
        .TICK_DIV   (TickDiv),
        .HOLD_TICKS (HoldTicks),
        .MAX_HOLD   (MaxHold)
    ) dut (
        .i_Clk    (clk),
        .i_Rst    (rst),
        .i_Req0   (req0),
        .i_Datos0 (d0),
        .i_Req1   (req1),
        .i_Datos1 (d1),
        .o_Gnt0   (gnt0),
        .o_Gnt1   (gnt1),
        .o_Datos1 (q1),
        .o_Datos2 (q2),
        .o_Datos3 (q3),
        .o_Datos4 (q4),
        .o_Blank  (blank)
    );

    typedef struct {
        logic        rst;
        logic        r0;
        logic [15:0] d0;
        logic        r1;
        logic [15:0] d1;
        logic        g0;
        logic        g1;
        logic [15:0] dat;
        logic        chk;
        logic        blank;
        string       name;
    } vec_t;

    typedef struct {
        logic        g0;
        logic        g1;
        logic        blank;
        logic        chk;
        logic [15:0] dat;
        string       name;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   checks = 0;
    int   failures = 0;

    function automatic vec_t mk(input int r, input int a0, input logic [15:0] x0, input int a1,
                                input logic [15:0] x1, input int g0, input int g1,
                                input logic [15:0] q, input int chk, input int bl,
                                input string name);
        vec_t v;
        v.rst = (r != 0);  v.r0 = (a0 != 0); v.d0 = x0; v.r1 = (a1 != 0); v.d1 = x1;
        v.g0 = (g0 != 0);  v.g1 = (g1 != 0); v.dat = q; v.chk = (chk != 0);
        v.blank = (bl != 0); v.name = name;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        rst = v.rst; req0 = v.r0; d0 = v.d0; req1 = v.r1; d1 = v.d1;
        e.g0 = v.g0; e.g1 = v.g1; e.blank = v.blank; e.chk = v.chk; e.dat = v.dat;
        e.name = v.name;
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (gnt0 !== e.g0 || gnt1 !== e.g1 || blank !== e.blank ||
                (e.chk && dat !== e.dat)) begin
                failures++;
                $display("FAIL %s: got gnt0=%0b gnt1=%0b blank=%0b dat=%h, want gnt0=%0b gnt1=%0b blank=%0b dat=%h%s",
                         e.name, gnt0, gnt1, blank, dat, e.g0, e.g1, e.blank, e.dat,
                         e.chk ? "" : " (dat unchecked)");
            end
        end
    end

    initial begin
        // Reset and idle
        tbl.push_back(mk(1, 0, 16'h0, 0, 16'h0, 0, 0, 16'h0000, 1, 1, "reset"));
        repeat (4) tbl.push_back(mk(0, 0, 16'h0, 0, 16'h0, 0, 0, 16'h0000, 1, 1, "idle"));
        // Single requester 0: grant, reload, drop, frozen hold, release after 8 cycles
        tbl.push_back(mk(0, 1, 16'h1234, 0, 16'h0, 1, 0, 16'h1234, 1, 0, "grant0"));
        tbl.push_back(mk(0, 1, 16'h1235, 0, 16'h0, 1, 0, 16'h1235, 1, 0, "reload0"));
        tbl.push_back(mk(0, 0, 16'h9999, 0, 16'h0, 0, 0, 16'h1235, 1, 0, "drop0"));
        repeat (5) tbl.push_back(mk(0, 0, 16'h9999, 0, 16'h0, 0, 0, 16'h1235, 1, 0, "hold0"));
        tbl.push_back(mk(0, 0, 16'h9999, 0, 16'h0, 0, 0, 16'h0000, 0, 1, "release0"));
        // Tie after reset goes to 0, then handover to 1 through a blank cycle
        tbl.push_back(mk(1, 0, 16'h0, 0, 16'h0, 0, 0, 16'h0000, 1, 1, "reset"));
        tbl.push_back(mk(0, 1, 16'h1234, 1, 16'hABCD, 1, 0, 16'h1234, 1, 0, "tie0"));
        repeat (8) tbl.push_back(mk(0, 1, 16'h1234, 1, 16'hABCD, 1, 0, 16'h1234, 1, 0, "own0"));
        tbl.push_back(mk(0, 0, 16'h1234, 1, 16'hABCD, 0, 0, 16'h0000, 0, 1, "switch"));
        tbl.push_back(mk(0, 0, 16'h0, 1, 16'hABCD, 0, 1, 16'hABCD, 1, 0, "grant1"));
        tbl.push_back(mk(0, 0, 16'h0, 1, 16'hABCD, 0, 1, 16'hABCD, 1, 0, "own1"));
        // Drop and re-raise: hold count keeps running, release still at 8 cycles
        tbl.push_back(mk(0, 0, 16'h0, 0, 16'hABCD, 0, 0, 16'hABCD, 1, 0, "drop1"));
        tbl.push_back(mk(0, 0, 16'h0, 1, 16'hABCD, 0, 1, 16'hABCD, 1, 0, "regrant1"));
        repeat (4) tbl.push_back(mk(0, 0, 16'h0, 0, 16'h5555, 0, 0, 16'hABCD, 1, 0, "hold1"));
        tbl.push_back(mk(0, 0, 16'h0, 0, 16'h5555, 0, 0, 16'h0000, 0, 1, "release1"));
        // Round-robin: last owner was 1, so a tie goes to 0
        tbl.push_back(mk(0, 1, 16'h0F0F, 1, 16'h1111, 1, 0, 16'h0F0F, 1, 0, "rr0"));
        repeat (8) tbl.push_back(mk(0, 1, 16'h0F0F, 1, 16'h1111, 1, 0, 16'h0F0F, 1, 0, "rr0_own"));
        tbl.push_back(mk(0, 0, 16'h0F0F, 1, 16'h1111, 0, 0, 16'h0000, 0, 1, "switch2"));
        // Reset during SWITCH restores the round-robin pointer
        tbl.push_back(mk(1, 0, 16'h0, 1, 16'h1111, 0, 0, 16'h0000, 1, 1, "rst_switch"));
        tbl.push_back(mk(0, 1, 16'h2222, 1, 16'h3333, 1, 0, 16'h2222, 1, 0, "tie_after_rst"));
        // Reset during OWN1
        tbl.push_back(mk(1, 0, 16'h0, 1, 16'h4444, 0, 0, 16'h0000, 1, 1, "reset"));
        tbl.push_back(mk(0, 0, 16'h0, 1, 16'h4444, 0, 1, 16'h4444, 1, 0, "grant1b"));
        tbl.push_back(mk(0, 0, 16'h0, 1, 16'h4445, 0, 1, 16'h4445, 1, 0, "reload1"));
        tbl.push_back(mk(1, 0, 16'h0, 1, 16'h4446, 0, 0, 16'h0000, 1, 1, "rst_own1"));
        tbl.push_back(mk(0, 1, 16'h5555, 1, 16'h6666, 1, 0, 16'h5555, 1, 0, "tie_after_rst2"));

        foreach (tbl[i]) apply(tbl[i]);

        // Long idle after reset
        apply(mk(1, 0, 16'h0, 0, 16'h0, 0, 0, 16'h0000, 1, 1, "reset"));
        repeat (16) apply(mk(0, 0, 16'h7777, 0, 16'h8888, 0, 0, 16'h0000, 1, 1, "idle_long"));

        // Continuous contention from reset
        apply(mk(1, 0, 16'h0, 0, 16'h0, 0, 0, 16'h0000, 1, 1, "reset"));
        for (int k = 0; k < 70; k++) begin
`ifdef DISPLAY_ARBITER_PREEMPT_EN
            int ph;
            int own;
            ph  = k % 21;
            own = (k / 21) % 2;
            if (ph == 20) begin
                apply(mk(0, 1, 16'hAAAA, 1, 16'hBBBB, 0, 0, 16'h0000, 0, 1, "preempt_gap"));
            end else begin
                apply(mk(0, 1, 16'hAAAA, 1, 16'hBBBB, (own == 0) ? 1 : 0, own,
                         (own != 0) ? 16'hBBBB : 16'hAAAA, 1, 0, "preempt_own"));
            end
`else
            apply(mk(0, 1, 16'hAAAA, 1, 16'hBBBB, 1, 0, 16'hAAAA, 1, 0, "contend_keep0"));
`endif
        end

        @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
